// File: rtl/register_file.sv
// MIPS 32-entry register file: two async read ports, one sync write port,
// a debug read port and a saturating accepted-write counter.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to Read_Data1/2.
module register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Read_Register1,
  input  logic [ADDR_WIDTH-1:0] Read_Register2,
  input  logic [ADDR_WIDTH-1:0] Write_Register,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] Dbg_Addr,
  output logic [DATA_WIDTH-1:0] Read_Data1,
  output logic [DATA_WIDTH-1:0] Read_Data2,
  output logic [DATA_WIDTH-1:0] Dbg_Data,
  output logic [CNT_WIDTH-1:0]  Write_Count
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [0:DEPTH-1];
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  w_wr_accept;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;
  logic [DATA_WIDTH-1:0] w_dbg;

  // Writes to $zero and writes during reset are dropped entirely.
  assign w_wr_accept = RegWrite && !rst && (Write_Register != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_cnt <= '0;
    end else if (w_wr_accept) begin
      r_regs[Write_Register] <= Write_Data;
      if (r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Index 0 reads as zero regardless of array contents; reset forces all reads low.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    w_dbg = '0;
    if (!rst) begin
      if (Read_Register1 != '0) w_rd1 = r_regs[Read_Register1];
      if (Read_Register2 != '0) w_rd2 = r_regs[Read_Register2];
      if (Dbg_Addr != '0)       w_dbg = r_regs[Dbg_Addr];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_accept && (Write_Register == Read_Register1)) w_rd1 = Write_Data;
      if (w_wr_accept && (Write_Register == Read_Register2)) w_rd2 = Write_Data;
`endif
    end
  end

  assign Read_Data1  = w_rd1;
  assign Read_Data2  = w_rd2;
  assign Dbg_Data    = w_dbg;
  assign Write_Count = r_cnt;

endmodule
